// File: rtl/jk_bank_ctrl.sv
// jk_bank_ctrl: two-port arbiter and sequencer for a JK flip-flop bank.
// Define JKCTRL_RR_EN for round-robin ties; otherwise req0 has fixed priority.
module jk_bank_ctrl #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             _rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] mask0,
  input  logic [WIDTH-1:0] mask1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] q
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic             gnt_q;
  logic [WIDTH-1:0] j_q;
  logic [WIDTH-1:0] k_q;
  logic [WIDTH-1:0] rdata_q;
  logic             done0_q;
  logic             done1_q;
  logic             busy_q;
`ifdef JKCTRL_RR_EN
  logic             rr_q;
`endif

  logic             gnt_d;
  logic [1:0]       op_d;
  logic [WIDTH-1:0] mask_d;
  logic [WIDTH-1:0] j_d;
  logic [WIDTH-1:0] k_d;

  // Pick the winner among the current requests and form its j/k pattern.
  always_comb begin
    gnt_d = 1'b0;
`ifdef JKCTRL_RR_EN
    if (req0 && req1) gnt_d = rr_q;
    else              gnt_d = req1;
`else
    gnt_d = ~req0;
`endif
    op_d   = gnt_d ? op1 : op0;
    mask_d = gnt_d ? mask1 : mask0;
    j_d    = mask_d & {WIDTH{op_d[1]}};
    k_d    = mask_d & {WIDTH{op_d[0]}};
  end

  // Transaction sequencer; every output is a register.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gnt_q   <= 1'b0;
      j_q     <= '0;
      k_q     <= '0;
      rdata_q <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef JKCTRL_RR_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req0 || req1) begin
            gnt_q   <= gnt_d;
            j_q     <= j_d;
            k_q     <= k_d;
            busy_q  <= 1'b1;
            state_q <= S_DRIVE;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        S_DRIVE: begin
          j_q     <= '0;
          k_q     <= '0;
          cnt_q   <= CNT_INIT;
          state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == 4'd0) state_q <= S_DONE;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        S_DONE: begin
          rdata_q <= q;
          done0_q <= ~gnt_q;
          done1_q <= gnt_q;
`ifdef JKCTRL_RR_EN
          rr_q    <= ~gnt_q;
`endif
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign j     = j_q;
  assign k     = k_q;
  assign rdata = rdata_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// tb_jk_bank_ctrl: directed vectors for jk_bank_ctrl with a JK bank model.
// Expected values are hand-computed for WIDTH=8, SETTLE=2.
module tb_jk_bank_ctrl;

  logic       clk;
  logic       _rst;
  logic       req0, req1;
  logic [1:0] op0, op1;
  logic [7:0] mask0, mask1;
  logic       done0, done1;
  logic [7:0] rdata;
  logic       busy;
  logic [7:0] j, k;
  logic [7:0] q = 8'h00;

  int tests = 0;
  int fails = 0;

  jk_bank_ctrl #(.WIDTH(8), .SETTLE(2)) dut (
    .clk(clk), ._rst(_rst),
    .req0(req0), .req1(req1),
    .op0(op0), .op1(op1),
    .mask0(mask0), .mask1(mask1),
    .done0(done0), .done1(done1),
    .rdata(rdata), .busy(busy),
    .j(j), .k(k), .q(q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // JK bank: Q+ = J & ~Q | ~K & Q per bit.
  always @(posedge clk) q <= (j & ~q) | (~k & q);

  typedef struct {
    bit         sel;
    logic [1:0] op;
    logic [7:0] mask;
    logic [7:0] ej;
    logic [7:0] ek;
    logic [7:0] erd;
  } vec_t;

  vec_t v [9];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    _rst = 1'b0;
    @(negedge clk);
    _rst = 1'b1;
  endtask

  task automatic run_txn(input bit sel, input logic [1:0] op,
                         input logic [7:0] mask, input logic [7:0] ej,
                         input logic [7:0] ek, input logic [7:0] erd,
                         input bit early, input string nm);
    int n;
    bit got;
    bit jk_bad;
    bit which;
    @(negedge clk);
    req0  = ~sel;
    req1  = sel;
    op0   = sel ? 2'b00 : op;
    op1   = sel ? op : 2'b00;
    mask0 = sel ? 8'h00 : mask;
    mask1 = sel ? mask : 8'h00;
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_j"}, 32'(j), 32'(ej));
    chk({nm, "_k"}, 32'(k), 32'(ek));
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    if (early) begin
      req0  = 1'b0;
      op0   = ~op0;
      mask0 = ~mask0;
    end
    n = 0;
    got = 1'b0;
    jk_bad = 1'b0;
    which = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (j != 8'h00 || k != 8'h00) jk_bad = 1'b1;
      if (done0 || done1) begin
        got = 1'b1;
        which = done1;
      end
    end
    chk({nm, "_gotdone"}, 32'(got), 32'd1);
    chk({nm, "_lat"}, 32'(n), 32'd4);
    chk({nm, "_id"}, 32'(which), 32'(sel));
    chk({nm, "_rdata"}, 32'(rdata), 32'(erd));
    chk({nm, "_jk_idle"}, 32'(jk_bad), 32'd0);
    req0 = 1'b0;
    req1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_pulse"}, 32'({done0, done1}), 32'd0);
    chk({nm, "_busy_off"}, 32'(busy), 32'd0);
    chk({nm, "_hold"}, 32'(rdata), 32'(erd));
  endtask

  initial begin
    int ord [4];
    int nd;
    int cyc;
    bit both;
    bit seen;

    v[0] = '{1'b0, 2'b10, 8'h0F, 8'h0F, 8'h00, 8'h0F};
    v[1] = '{1'b1, 2'b11, 8'hFF, 8'hFF, 8'hFF, 8'hF0};
    v[2] = '{1'b1, 2'b11, 8'hFF, 8'hFF, 8'hFF, 8'h0F};
    v[3] = '{1'b0, 2'b01, 8'hFF, 8'h00, 8'hFF, 8'h00};
    v[4] = '{1'b0, 2'b10, 8'hA5, 8'hA5, 8'h00, 8'hA5};
    v[5] = '{1'b0, 2'b01, 8'h00, 8'h00, 8'h00, 8'hA5};
    v[6] = '{1'b1, 2'b00, 8'hFF, 8'h00, 8'h00, 8'hA5};
    v[7] = '{1'b1, 2'b10, 8'h5A, 8'h5A, 8'h00, 8'hFF};
    v[8] = '{1'b0, 2'b11, 8'hF0, 8'hF0, 8'hF0, 8'h0F};

    _rst  = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    op0   = 2'b00;
    op1   = 2'b00;
    mask0 = 8'h00;
    mask1 = 8'h00;
    #1;
    chk("rst_state", 32'({j, k, rdata, done0, done1, busy}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    _rst = 1'b1;

    for (int i = 0; i < 9; i++)
      run_txn(v[i].sel, v[i].op, v[i].mask, v[i].ej, v[i].ek,
              v[i].erd, 1'b0, $sformatf("vec%0d", i));

    // Simultaneous requests, four transactions, bank held.
    do_reset();
    @(negedge clk);
    op0 = 2'b00; op1 = 2'b00;
    mask0 = 8'hFF; mask1 = 8'hFF;
    req0 = 1'b1; req1 = 1'b1;
    nd = 0;
    cyc = 0;
    both = 1'b0;
    while (nd < 4 && cyc < 40) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (done0 && done1) both = 1'b1;
      if (done0 || done1) begin
        ord[nd] = done1 ? 1 : 0;
        nd++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("tie_count", 32'(nd), 32'd4);
    chk("tie_both", 32'(both), 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i < nd) begin
`ifdef JKCTRL_RR_EN
        chk($sformatf("tie_ord%0d", i), 32'(ord[i]), 32'(i % 2));
`else
        chk($sformatf("tie_ord%0d", i), 32'(ord[i]), 32'd0);
`endif
      end
    end
    chk("tie_rdata", 32'(rdata), 32'h0F);
    repeat (2) @(negedge clk);

    // Reset during SETTLE aborts; bank keeps the toggle from E1.
    req0 = 1'b1; op0 = 2'b11; mask0 = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    _rst = 1'b0;
    req0 = 1'b0;
    #1;
    chk("abort_outs", 32'({j, k, rdata, done0, done1, busy}), 32'd0);
    @(negedge clk);
    _rst = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done0 || done1) seen = 1'b1;
    end
    chk("abort_nodone", 32'(seen), 32'd0);
    run_txn(1'b0, 2'b10, 8'h01, 8'h01, 8'h00, 8'hF1, 1'b0, "post_rst");

    // Request dropped and command changed one cycle after grant.
    run_txn(1'b0, 2'b01, 8'hFF, 8'h00, 8'hFF, 8'h00, 1'b1, "early");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jk_bank_ctrl.md
# jk_bank_ctrl

Sequencing controller and two-port arbiter for a bank of `WIDTH` gate-level JK flip-flops clocked on `clk`. Two requesters issue per-bit hold/reset/set/toggle commands. The controller grants one at a time, drives the bank's `j`/`k` vectors for exactly one clock, and waits a settle window for the gate-level edge logic to resolve. It then returns the bank state to the granted requester with a one-cycle done pulse.

## Interface
- `WIDTH`, 8: number of JK flip-flops in the bank (1..32).
- `SETTLE`, 2: hold cycles (j=k=0) after the drive cycle before sampling `q` (1..15).

Ports:
- `clk`  in  1  system clock; bank flip-flops share this clock.
- `_rst`  in  1  reset, asynchronous, active-low.
- `req0`, `req1`  in  1  transaction request, held high until matching `done`.
- `op0`, `op1`  in  2  command: 00 hold, 01 reset, 10 set, 11 toggle.
- `mask0`, `mask1`  in  WIDTH  bits the command applies to; unmasked bits hold.
- `done0`, `done1`  out  1  one-cycle completion pulse to the granted requester.
- `rdata`  out  WIDTH  bank state captured at completion; valid while `done*` is high and held until the next completion.
- `busy`  out  1  high in any state other than IDLE.
- `j`, `k`  out  WIDTH  to the bank's JK inputs.
- `q`  in  WIDTH  from the bank's `q` outputs.

## Operation
- States: IDLE, DRIVE, SETTLE, DONE.
- **IDLE**
  - If any `req*` is sampled high, select the winner.
  - Latch the winner's `op`/`mask` and the granted id.
  - Register `j = mask & {WIDTH{op[1]}}` and `k = mask & {WIDTH{op[0]}}`.
  - Go to DRIVE.
- **DRIVE**
  - `j`/`k` are valid for exactly one cycle.
  - Clear `j`/`k` to 0 and load the settle counter with `SETTLE-1`.
  - Go to SETTLE.
- **SETTLE**
  - `j = k = 0`.
  - Decrement the counter; at 0, go to DONE.
- **DONE**
  - `rdata <= q`.
  - Pulse `done` for the granted id only.
  - Update the round-robin pointer to the other requester.
  - Return to IDLE.
- `op`/`mask` are sampled only at the grant edge; changes later in the transaction are ignored.
- Dropping `req` mid-transaction does not abort it; `done` still pulses.
- `mask = 0` or `op = 00` still runs the full sequence and returns `q` in `rdata`.
- Bits outside `mask` always see j=k=0, so they hold state.
- `j`/`k` are never nonzero outside DRIVE. This rules out repeated toggling on consecutive edges.
- Arbitration with both requests high in IDLE: see Configuration.
- A requester that keeps `req` high after `done` is re-arbitrated in the next IDLE cycle as a new transaction.

## Timing
- Reset (asynchronous, while `_rst` = 0):
  - State goes to IDLE.
  - `j = k = 0`, `done0 = done1 = 0`, `rdata = 0`, `busy = 0`.
  - Round-robin pointer set to favour requester 0.
- Reset asserted mid-transaction: the transaction is aborted immediately; no `done` is issued. Bank contents are whatever the last completed drive edge produced.
- Request sampled at edge E0 (state IDLE):
  - `j`/`k` valid E0..E1.
  - The bank captures at E1.
  - SETTLE spans E1..E(1+SETTLE).
  - `done` and `rdata` are high/valid in cycle E(2+SETTLE)..E(3+SETTLE).
- Latency from request to `done` is 2+SETTLE cycles (4 at default). Throughput is one transaction per 3+SETTLE cycles, including the IDLE cycle.
- `busy` rises at E0 and falls at E(3+SETTLE).

## Configuration
- `JKCTRL_RR_EN` defined:
  - Round-robin arbitration on simultaneous requests.
  - The requester not served in the most recent completed transaction wins.
  - The pointer starts at requester 0 after reset.
- Not defined:
  - Fixed priority: `req0` always wins ties.
  - The pointer logic is absent.
  - `req1` can starve while `req0` is held.

## Test plan
- Reset, then `req0` with op=10, mask=0x0F (WIDTH=8, SETTLE=2) → `j` = 0x0F for one cycle; `done0` 4 cycles after request; `rdata` = 0x0F.
- From 0x0F, `req1` op=11, mask=0xFF → `k` = `j` = 0xFF for one cycle only; `done1`; `rdata` = 0xF0. A second identical request gives `rdata` = 0x0F, confirming a single toggle per transaction.
- Simultaneous `req0`/`req1` held high for 4 transactions:
  - With `JKCTRL_RR_EN`: done order 0,1,0,1.
  - Without: done order 0,0,0,0.
- `req0` op=01 mask=0x00 while bank = 0xA5 → `j` = `k` = 0 throughout; `rdata` = 0xA5; latency still 4 cycles.
- `_rst` pulsed low during SETTLE → `j`/`k`/`done*`/`rdata`/`busy` go to 0 asynchronously; no `done` follows; the next request completes normally.
- Change `op0`/`mask0` and drop `req0` one cycle after the grant → the original command executes and `done0` still pulses.
